layer_bias_rx: RTL and testbench
================================

// Module: layer_bias_rx
// PURPOSE
// - Receiving end of the layer bias stream: 64-bit beats, each carrying two signed 32-bit biases, with a valid/ready/last handshake.
// - Unpacks the stream into a BIAS_NUM-entry bias register bank.
// - Serves biases to the convolution/accumulate stage through a registered random-access read port.
// - One load per layer; the bank is re-armed by a start pulse.
// PARAMETERS
// - BIAS_NUM   32  number of biases per layer (even; beats per load = BIAS_NUM/2)
// - BIAS_W     32  bias width, two's complement
// - DATA_W     64  stream beat width (= 2*BIAS_W)
// PORTS
// - sclk         in   1       clock
// - s_rst_n      in   1       reset, asynchronous, active-low
// - start        in   1       one-cycle pulse: arm a new load
// - bias_data    in   64      beat; [31:0] = bias[2k], [63:32] = bias[2k+1]
// - bias_valid   in   1       beat valid
// - bias_last    in   1       marks the final beat (beat BIAS_NUM/2-1)
// - bias_ready   out  1       beat accept; transfer = bias_valid & bias_ready
// - rd_addr      in   5       bias index, 0..BIAS_NUM-1 (clog2 BIAS_NUM)
// - rd_data      out  32      bias[rd_addr], registered
// - load_done    out  1       one-cycle pulse on load completion
// - bias_loaded  out  1       level: bank holds a complete load
// - err_len      out  1       sticky: last mismatch on the most recent load
// BEHAVIOUR
// - Reset values: all outputs 0, FSM = IDLE, beat counter 0, all bank entries 0.
// - FSM states IDLE, LOAD, DONE:
//   - IDLE --start--> LOAD
//   - LOAD --accepted beat with cnt==BIAS_NUM/2-1, or accepted beat with bias_last=1--> DONE
//   - DONE --start--> LOAD
// - Actions on start (from IDLE or DONE):
//   - beat counter <= 0; bias_loaded <= 0; err_len <= 0.
//   - Bank contents are retained until overwritten.
// - start while in LOAD is ignored; the load in progress continues.
// - bias_ready = 1 only in LOAD (registered, asserted the cycle after start). It is 0 in IDLE and DONE, so stray beats stall upstream.
// - Accepted beat k:
//   - bank[2k] <= bias_data[31:0]; bank[2k+1] <= bias_data[63:32]; cnt <= k+1.
//   - No sign or width conversion; bits are stored verbatim.
// - Valid gaps (bias_valid=0 during LOAD) hold counter and bank; no timeout.
// - Length check on the accepted final-position beat (cnt==BIAS_NUM/2-1): if bias_last=0, set err_len.
// - Early last (bias_last=1 with cnt<BIAS_NUM/2-1): set err_len and go to DONE. Remaining entries keep their old values.
// - Entering DONE:
//   - load_done = 1 for exactly one cycle (the cycle after the last transfer); bias_loaded = 1 (held).
//   - bias_ready drops the same cycle, so at most BIAS_NUM/2 beats are accepted per load.
// - Read port:
//   - rd_data <= bank[rd_addr] each cycle; latency 1, available in every state.
//   - Read of an entry written in the same cycle returns the old value (read-before-write).
//   - rd_addr >= BIAS_NUM returns 0.
// - Reset mid-load: everything returns to reset values immediately; the upstream sender is re-aligned by its own reset.
// - Simultaneous start and final beat: in LOAD, start is ignored; in DONE, bias_ready=0, so no beat is possible.
// STRUCTURE
// - Shared package (cnn_pkg): BIAS_NUM, BIAS_W, DATA_W, the IDX_W=clog2(BIAS_NUM) constant, and the bias_rx_state_t enum {IDLE, LOAD, DONE}.
// - One natural sub-module: bias_regfile (2-write-per-cycle even/odd bank, 1 registered read port, async-reset clear).
// - FSM, counter, handshake and checks stay in layer_bias_rx.
// TESTING
// - Nominal load:
//   - Stimulus: start, then 16 back-to-back beats of the layer-2 set (bias[0]=692 ... bias[16]=-199 ... bias[31]=560), last on beat 15.
//   - Response: load_done pulse one cycle after beat 15; err_len=0; rd_addr=16 -> rd_data=32'hFFFF_FF39 next cycle; rd_addr=31 -> 560.
// - Stall: beats presented before start.
//   - Response: bias_ready=0, bank unchanged, counter 0.
//   - Then random valid gaps (1-5 cycles): still exactly 16 transfers, same final bank contents.
// - Early last on beat 9:
//   - Response: DONE after 10 transfers; err_len=1; bias_loaded=1; entries 20..31 hold the previous load's values.
// - Missing last (bias_last=0 on beat 15):
//   - Response: DONE, err_len=1; beat 16 offered afterwards is not accepted (bias_ready=0).
// - Reset mid-load: s_rst_n low after beat 7.
//   - Response: all outputs 0, bank reads 0; a fresh start plus 16 beats then loads correctly.
// - Reload: second start from DONE with all-different values.
//   - Response: bias_loaded drops until the new load_done; reads during LOAD return either old or new data per entry, never X.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN layer-parameter receivers.
//   BIAS_NUM : biases per layer (even, two per stream beat)
//   BIAS_W   : bias width, two's complement
//   DATA_W   : stream beat width, two biases side by side
//   IDX_W    : bias index width
//   BEATS    : beats per complete load
//   ROW_W    : index width of one half-bank (even or odd biases)
//   CNT_W    : beat counter width, wide enough to count up to BEATS
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int BIAS_NUM = 32;
  localparam int BIAS_W   = 32;
  localparam int DATA_W   = 2 * BIAS_W;
  localparam int IDX_W    = $clog2(BIAS_NUM);
  localparam int BEATS    = BIAS_NUM / 2;
  localparam int ROW_W    = IDX_W - 1;
  localparam int CNT_W    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } bias_rx_state_t;

endpackage

// File: rtl/bias_regfile.sv
// ---------------------------------------------------------------------------
// bias_regfile
// Bias storage split into an even bank and an odd bank so that one stream
// beat (two biases) is written in a single cycle. One registered read port.
// Ports:
//   sclk, s_rst_n : clock, async active-low reset (clears every entry)
//   wr_en         : write both halves of row wr_row
//   wr_row        : beat index being written
//   wr_even       : bias[2*wr_row]
//   wr_odd        : bias[2*wr_row+1]
//   rd_addr       : bias index to read
//   rd_data       : bias[rd_addr] one cycle later, 0 when out of range
// ---------------------------------------------------------------------------
module bias_regfile
  import cnn_pkg::*;
(
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [BIAS_W-1:0] wr_even,
  input  logic [BIAS_W-1:0] wr_odd,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [BIAS_W-1:0] rd_data
);

  logic [BIAS_W-1:0] even_bank [BEATS];
  logic [BIAS_W-1:0] odd_bank  [BEATS];

  logic [ROW_W-1:0] rd_row;
  logic             rd_in_range;

  assign rd_row      = rd_addr[IDX_W-1:1];
  assign rd_in_range = ({1'b0, rd_addr} < (IDX_W+1)'(BIAS_NUM));

  // Both halves of a beat land in the same row; reset clears the whole bank
  // so a fresh layer never sees stale biases from before the reset.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < BEATS; i++) begin
        even_bank[i] <= '0;
        odd_bank[i]  <= '0;
      end
    end else if (wr_en) begin
      even_bank[wr_row] <= wr_even;
      odd_bank[wr_row]  <= wr_odd;
    end
  end

  // Registered read sampling the bank before this cycle's write takes
  // effect, so a same-cycle write returns the previous contents.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_data <= '0;
    end else if (!rd_in_range) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_addr[0] ? odd_bank[rd_row] : even_bank[rd_row];
    end
  end

endmodule

// File: rtl/layer_bias_rx.sv
// ---------------------------------------------------------------------------
// layer_bias_rx
// Receives one layer's biases over a valid/ready/last stream (two biases per
// beat), stores them in bias_regfile and serves them on a registered read
// port. A start pulse arms each load.
// Ports:
//   sclk, s_rst_n : clock, async active-low reset
//   start         : one-cycle pulse, arms a new load (ignored mid-load)
//   bias_data     : beat, [31:0] even bias, [63:32] odd bias
//   bias_valid    : beat valid
//   bias_last     : final beat marker
//   bias_ready    : beat accept, high only while loading
//   rd_addr       : bias index to read
//   rd_data       : registered bias[rd_addr]
//   load_done     : one-cycle pulse after the load-ending transfer
//   bias_loaded   : level, bank holds a completed load
//   err_len       : sticky, the latest load had a length/last mismatch
// ---------------------------------------------------------------------------
module layer_bias_rx
  import cnn_pkg::*;
(
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              bias_valid,
  input  logic              bias_last,
  output logic              bias_ready,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [BIAS_W-1:0] rd_data,
  output logic              load_done,
  output logic              bias_loaded,
  output logic              err_len
);

  bias_rx_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ready_nxt, done_nxt, loaded_nxt, err_nxt;
  logic             xfer, final_pos;

  assign xfer      = bias_valid & bias_ready;
  assign final_pos = (cnt == CNT_W'(BEATS - 1));

  // A load ends on whichever comes first: the final beat position or an
  // asserted last. Any disagreement between the two flags a length error.
  // Ready is precomputed from the next state so it drops together with the
  // entry into DONE, capping each load at BEATS transfers.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    loaded_nxt = bias_loaded;
    err_nxt    = err_len;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = LOAD;
          cnt_nxt    = '0;
          loaded_nxt = 1'b0;
          err_nxt    = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (final_pos || bias_last) begin
            state_nxt  = DONE;
            done_nxt   = 1'b1;
            loaded_nxt = 1'b1;
            if (final_pos != bias_last) begin
              err_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ready_nxt = (state_nxt == LOAD);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bias_ready  <= 1'b0;
      load_done   <= 1'b0;
      bias_loaded <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bias_ready  <= ready_nxt;
      load_done   <= done_nxt;
      bias_loaded <= loaded_nxt;
      err_len     <= err_nxt;
    end
  end

  // The beat counter doubles as the row address: beat k fills bias 2k/2k+1.
  bias_regfile u_regfile (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .wr_en   (xfer),
    .wr_row  (cnt[ROW_W-1:0]),
    .wr_even (bias_data[BIAS_W-1:0]),
    .wr_odd  (bias_data[DATA_W-1:BIAS_W]),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_layer_bias_rx.sv
module tb_layer_bias_rx;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] bias_data = '0;
  logic        bias_valid = 1'b0;
  logic        bias_last = 1'b0;
  logic        bias_ready;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        load_done;
  logic        bias_loaded;
  logic        err_len;

  layer_bias_rx dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .start       (start),
    .bias_data   (bias_data),
    .bias_valid  (bias_valid),
    .bias_last   (bias_last),
    .bias_ready  (bias_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .load_done   (load_done),
    .bias_loaded (bias_loaded),
    .err_len     (err_len)
  );

  always #5 sclk = ~sclk;

  // Reference model: what the bank should hold and the load status flags.
  logic [31:0] ref_bank [32];
  int          m_cnt;
  bit          m_loading;
  bit          m_loaded;
  bit          m_err;

  int checks = 0;
  int passed = 0;
  int xfers;

  // Compare one observed value against the model's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic modelClear();
    for (int i = 0; i < 32; i++) ref_bank[i] = '0;
    m_cnt = 0; m_loading = 0; m_loaded = 0; m_err = 0;
  endtask

  task automatic modelStart();
    if (!m_loading) begin
      m_cnt = 0; m_loaded = 0; m_err = 0; m_loading = 1;
    end
  endtask

  task automatic modelBeat(input logic [63:0] d, input logic last);
    bit fin;
    if (!m_loading) return;
    ref_bank[2*m_cnt]   = d[31:0];
    ref_bank[2*m_cnt+1] = d[63:32];
    fin = (m_cnt == 15);
    m_cnt++;
    if (fin || last) begin
      m_loading = 0;
      m_loaded  = 1;
      m_err     = (fin != last);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    modelStart();
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [63:0] d, input logic last);
    bit acc = 0;
    bias_data  = d;
    bias_last  = last;
    bias_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = bias_ready;
      tick();
    end
    bias_valid = 1'b0;
    bias_last  = 1'b0;
    if (!acc) checkOutput("ready_timeout", 64'd0, 64'd1);
    else begin
      xfers++;
      modelBeat(d, last);
    end
  endtask

  task automatic checkBank(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick();
      checkOutput($sformatf("%s[%0d]", tag, i), {32'd0, rd_data}, {32'd0, ref_bank[i]});
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_ready"},  {63'd0, bias_ready},  {63'd0, m_loading});
    checkOutput({tag, "_loaded"}, {63'd0, bias_loaded}, {63'd0, m_loaded});
    checkOutput({tag, "_err"},    {63'd0, err_len},     {63'd0, m_err});
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [31:0] l2 [32];
  logic [63:0] beats [16];
  logic [31:0] old_val;

  initial begin
    modelClear();

    // Reset state.
    #2;
    checkOutput("rst_ready", {63'd0, bias_ready}, 64'd0);
    checkOutput("rst_done", {63'd0, load_done}, 64'd0);
    checkOutput("rst_loaded", {63'd0, bias_loaded}, 64'd0);
    checkOutput("rst_err", {63'd0, err_len}, 64'd0);
    checkOutput("rst_rd", {32'd0, rd_data}, 64'd0);
    tick();
    s_rst_n = 1'b1;
    tick();

    // Beats offered before start must stall.
    bias_data = rnd64(); bias_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_ready", {63'd0, bias_ready}, 64'd0);
    end
    bias_valid = 1'b0;
    rd_addr = 5'd0; tick();
    checkOutput("stall_bank0", {32'd0, rd_data}, 64'd0);

    // Nominal layer-2 load, back-to-back, last on beat 15.
    for (int i = 0; i < 32; i++) l2[i] = $urandom;
    l2[0] = 32'd692; l2[16] = -32'sd199; l2[31] = 32'd560;
    pulseStart();
    checkStatus("nom_arm");
    xfers = 0;
    for (int k = 0; k < 16; k++) applyStimulus({l2[2*k+1], l2[2*k]}, k == 15);
    checkOutput("nom_done", {63'd0, load_done}, 64'd1);
    checkStatus("nom_end");
    tick();
    checkOutput("nom_done_pulse", {63'd0, load_done}, 64'd0);
    rd_addr = 5'd16; tick();
    checkOutput("nom_rd16", {32'd0, rd_data}, {32'd0, 32'hFFFF_FF39});
    rd_addr = 5'd31; tick();
    checkOutput("nom_rd31", {32'd0, rd_data}, 64'd560);
    checkBank("nom");

    // Random valid gaps: still 16 transfers, bank matches model.
    pulseStart();
    xfers = 0;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(1, 5)) tick();
      applyStimulus(rnd64(), k == 15);
    end
    checkOutput("gap_xfers", 64'(xfers), 64'd16);
    checkStatus("gap");
    checkBank("gap");

    // Early last on beat 9.
    pulseStart();
    xfers = 0;
    for (int k = 0; k < 10; k++) applyStimulus(rnd64(), k == 9);
    checkOutput("early_done", {63'd0, load_done}, 64'd1);
    checkOutput("early_xfers", 64'(xfers), 64'd10);
    checkStatus("early");
    checkBank("early");

    // Missing last: DONE after 16 beats with err_len, extra beat refused.
    pulseStart();
    for (int k = 0; k < 16; k++) applyStimulus(rnd64(), 1'b0);
    checkStatus("nolast");
    bias_data = rnd64(); bias_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("nolast_ready", {63'd0, bias_ready}, 64'd0);
    end
    bias_valid = 1'b0;
    checkBank("nolast");

    // Reset after beat 7, then a clean reload.
    pulseStart();
    for (int k = 0; k < 8; k++) applyStimulus(rnd64(), 1'b0);
    #3;
    s_rst_n = 1'b0;
    modelClear();
    #1;
    checkOutput("mrst_ready", {63'd0, bias_ready}, 64'd0);
    checkOutput("mrst_loaded", {63'd0, bias_loaded}, 64'd0);
    checkOutput("mrst_rd", {32'd0, rd_data}, 64'd0);
    tick();
    s_rst_n = 1'b1;
    tick();
    checkBank("mrst_clear");
    pulseStart();
    for (int k = 0; k < 16; k++) applyStimulus(rnd64(), k == 15);
    checkStatus("mrst_reload");
    checkBank("mrst_reload");

    // Reload from DONE with fresh values; a stray start mid-load is ignored.
    for (int k = 0; k < 16; k++) beats[k] = rnd64();
    old_val = ref_bank[20];
    pulseStart();
    checkOutput("reload_loaded_low", {63'd0, bias_loaded}, 64'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        start = 1'b1; tick(); start = 1'b0;
        checkOutput("reload_start_ign", {63'd0, bias_ready}, 64'd1);
      end
      if (k == 10) begin
        rd_addr = 5'd20;
        applyStimulus(beats[k], 1'b0);
        checkOutput("reload_mid", {63'd0, (rd_data === old_val) || (rd_data === beats[10][31:0])}, 64'd1);
      end else begin
        applyStimulus(beats[k], k == 15);
      end
    end
    checkOutput("reload_done", {63'd0, load_done}, 64'd1);
    checkStatus("reload");
    checkBank("reload");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
